// File: rtl/cred_enroll_ctrl.sv
// Credential enrollment controller: collects a 4-nibble ID and a password entered
// twice, then writes all eight nibbles into the ID and password RAMs of one user slot.
module cred_enroll_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       enroll_start,
  input  logic [1:0] slot_sel,
  input  logic       entry_push,
  input  logic       cancel_push,
  input  logic [3:0] nibble_in,
  output logic       id_we,
  output logic [3:0] id_waddr,
  output logic [3:0] id_wdata,
  output logic       pwd_we,
  output logic [4:0] pwd_waddr,
  output logic [3:0] pwd_wdata,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [1:0] phase,
  output logic [1:0] digit_cnt,
  output logic [3:0] disp_nibble
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER_ID,
    S_ENTER_PWD,
    S_CONFIRM,
    S_WRITE,
    S_DONE,
    S_FAIL
  } state_e;

  state_e          state_q;
  logic [1:0]      slot_q;
  logic [1:0]      cnt_q;
  logic [2:0]      wcnt_q;
  logic            mism_q;
  logic [3:0][3:0] id_buf_q;
  logic [3:0][3:0] pwd_buf_q;

  logic            id_we_q;
  logic [3:0]      id_waddr_q;
  logic [3:0]      id_wdata_q;
  logic            pwd_we_q;
  logic [4:0]      pwd_waddr_q;
  logic [3:0]      pwd_wdata_q;
  logic            busy_q;
  logic            done_q;
  logic            fail_q;
  logic [1:0]      phase_q;
  logic [3:0]      disp_q;

  logic            neq;
  logic            emit;

  // emit: a RAM write for index wcnt_q is registered this edge; the first write
  // is issued on the same edge as the matching 4th confirm push
  always_comb begin
    neq  = (nibble_in != pwd_buf_q[cnt_q]);
    emit = 1'b0;
    if (state_q == S_WRITE && wcnt_q != 3'd0) begin
      emit = 1'b1;
    end
    if (state_q == S_CONFIRM && entry_push && !cancel_push &&
        cnt_q == 2'd3 && !(mism_q || neq)) begin
      emit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      slot_q      <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      mism_q      <= 1'b0;
      id_buf_q    <= '0;
      pwd_buf_q   <= '0;
      id_we_q     <= 1'b0;
      id_waddr_q  <= '0;
      id_wdata_q  <= '0;
      pwd_we_q    <= 1'b0;
      pwd_waddr_q <= '0;
      pwd_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      phase_q     <= '0;
      disp_q      <= '0;
    end else begin
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      id_we_q  <= 1'b0;
      pwd_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enroll_start) begin
            slot_q  <= slot_sel;
            cnt_q   <= '0;
            mism_q  <= 1'b0;
            busy_q  <= 1'b1;
            phase_q <= 2'd1;
            state_q <= S_ENTER_ID;
          end
        end
        S_ENTER_ID: begin
          if (cancel_push) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            phase_q <= '0;
            cnt_q   <= '0;
          end else if (entry_push) begin
            id_buf_q[cnt_q] <= nibble_in;
            disp_q          <= nibble_in;
            cnt_q           <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q <= S_ENTER_PWD;
              phase_q <= 2'd2;
            end
          end
        end
        S_ENTER_PWD: begin
          if (cancel_push) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            phase_q <= '0;
            cnt_q   <= '0;
          end else if (entry_push) begin
            pwd_buf_q[cnt_q] <= nibble_in;
            disp_q           <= nibble_in;
            cnt_q            <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q <= S_CONFIRM;
              phase_q <= 2'd3;
            end
          end
        end
        S_CONFIRM: begin
          if (cancel_push) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            phase_q <= '0;
            cnt_q   <= '0;
          end else if (entry_push) begin
            disp_q <= nibble_in;
            cnt_q  <= cnt_q + 2'd1;
            mism_q <= mism_q | neq;
            if (cnt_q == 2'd3) begin
              phase_q <= '0;
              if (mism_q || neq) begin
                state_q <= S_FAIL;
                fail_q  <= 1'b1;
              end else begin
                state_q <= S_WRITE;
                wcnt_q  <= 3'd1;
              end
            end
          end
        end
        S_WRITE: begin
          if (wcnt_q == 3'd0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + 3'd1;
          end
        end
        S_DONE, S_FAIL: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          phase_q <= '0;
        end
      endcase
      if (emit) begin
        id_we_q     <= ~wcnt_q[2];
        pwd_we_q    <= wcnt_q[2];
        id_waddr_q  <= {slot_q, wcnt_q[1:0]};
        id_wdata_q  <= id_buf_q[wcnt_q[1:0]];
        pwd_waddr_q <= {1'b0, slot_q, wcnt_q[1:0]};
        pwd_wdata_q <= pwd_buf_q[wcnt_q[1:0]];
      end
    end
  end

  assign id_we       = id_we_q;
  assign id_waddr    = id_waddr_q;
  assign id_wdata    = id_wdata_q;
  assign pwd_we      = pwd_we_q;
  assign pwd_waddr   = pwd_waddr_q;
  assign pwd_wdata   = pwd_wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign phase       = phase_q;
  assign digit_cnt   = cnt_q;
  assign disp_nibble = disp_q;

endmodule

// File: tb/tb_cred_enroll_ctrl.sv
// Self-checking bench for cred_enroll_ctrl: directed test-plan cases plus randomized
// enrollments checked against a transaction-level model and a reference RAM image.
module tb_cred_enroll_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enroll_start = 1'b0;
  logic [1:0] slot_sel = '0;
  logic       entry_push = 1'b0;
  logic       cancel_push = 1'b0;
  logic [3:0] nibble_in = '0;
  logic       id_we;
  logic [3:0] id_waddr;
  logic [3:0] id_wdata;
  logic       pwd_we;
  logic [4:0] pwd_waddr;
  logic [3:0] pwd_wdata;
  logic       busy;
  logic       done;
  logic       fail;
  logic [1:0] phase;
  logic [1:0] digit_cnt;
  logic [3:0] disp_nibble;

  int n_chk = 0;
  int n_err = 0;
  int id_wr = 0, pwd_wr = 0, both_wr = 0, done_seen = 0, fail_seen = 0;
  int exp_succ = 0, exp_fail = 0;

  logic [3:0] ref_id [16];
  logic [3:0] ref_pwd[32];
  logic [3:0] sh_id  [16];
  logic [3:0] sh_pwd [32];
  logic [3:0] m_disp = '0;
  bit         cnt_known = 1'b1;

  always #5 clk = ~clk;

  cred_enroll_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .enroll_start(enroll_start),
    .slot_sel    (slot_sel),
    .entry_push  (entry_push),
    .cancel_push (cancel_push),
    .nibble_in   (nibble_in),
    .id_we       (id_we),
    .id_waddr    (id_waddr),
    .id_wdata    (id_wdata),
    .pwd_we      (pwd_we),
    .pwd_waddr   (pwd_waddr),
    .pwd_wdata   (pwd_wdata),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .phase       (phase),
    .digit_cnt   (digit_cnt),
    .disp_nibble (disp_nibble)
  );

  // Shadow RAMs capture whatever the DUT actually writes
  always @(negedge clk) begin
    if (rst) begin
      if (id_we) begin sh_id[id_waddr] = id_wdata; id_wr++; end
      if (pwd_we) begin sh_pwd[pwd_waddr] = pwd_wdata; pwd_wr++; end
      if (id_we && pwd_we) both_wr++;
      if (done) done_seen++;
      if (fail) fail_seen++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pk(input logic [3:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] v, input int k);
    return v[4*k +: 4];
  endfunction

  task automatic idle_push();
    nibble_in  = 4'($urandom);
    entry_push = 1'b1;
    tick();
    entry_push = 1'b0;
    chk("idle_push", {busy, phase, disp_nibble}, {1'b0, 2'b00, m_disp});
    if (cnt_known) chk("idle_dcnt", digit_cnt, 0);
  endtask

  // One full enrollment transaction; cpos = push index carrying a cancel (-1: none)
  task automatic do_enroll(input logic [1:0] slot, input logic [15:0] idv, pwv, cfv,
                           input int cpos, input bit xstart, input bit wpush);
    logic [3:0] n;
    int         ph;
    slot_sel     = slot;
    enroll_start = 1'b1;
    tick();
    enroll_start = 1'b0;
    chk("start_state", {busy, phase, digit_cnt}, {1'b1, 2'd1, 2'd0});
    chk("start_disp", disp_nibble, m_disp);
    for (int p = 0; p < 12; p++) begin
      ph = p / 4;
      n  = (ph == 0) ? nib(idv, p % 4) : (ph == 1) ? nib(pwv, p % 4) : nib(cfv, p % 4);
      if (xstart && p == 2) begin
        enroll_start = 1'b1;
        slot_sel     = slot + 2'd1;
      end
      nibble_in   = n;
      entry_push  = 1'b1;
      cancel_push = (p == cpos);
      tick();
      entry_push   = 1'b0;
      cancel_push  = 1'b0;
      enroll_start = 1'b0;
      if (p == cpos) begin
        chk("cancel_idle", {busy, phase}, 0);
        chk("cancel_disp", disp_nibble, m_disp);
        chk("cancel_pulse", {done, fail, id_we, pwd_we}, 0);
        repeat (2) tick();
        chk("cancel_quiet", {busy, done, fail, id_we, pwd_we}, 0);
        cnt_known = 1'b0;
        return;
      end
      m_disp = n;
      chk("entry_disp", disp_nibble, n);
      if (p < 11) begin
        chk("entry_phase", phase, (p + 1) / 4 + 1);
        chk("entry_dcnt", digit_cnt, (p + 1) % 4);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    if (cfv != pwv) begin
      exp_fail++;
      chk("fail_pulse", {busy, fail, done, id_we, pwd_we}, 5'b11000);
      tick();
      chk("fail_end", {busy, fail, phase}, 0);
    end else begin
      for (int k = 0; k < 8; k++) begin
        chk("wr_en", {id_we, pwd_we}, (k < 4) ? 2'b10 : 2'b01);
        if (k < 4) begin
          chk("wr_id", {id_waddr, id_wdata}, {slot, 2'(k), nib(idv, k)});
          ref_id[{slot, 2'(k)}] = nib(idv, k);
        end else begin
          chk("wr_pwd", {pwd_waddr, pwd_wdata}, {1'b0, slot, 2'(k - 4), nib(pwv, k - 4)});
          ref_pwd[{1'b0, slot, 2'(k - 4)}] = nib(pwv, k - 4);
        end
        chk("wr_state", {busy, done, phase, digit_cnt, disp_nibble}, {2'b10, 4'd0, m_disp});
        if (wpush && (k == 2 || k == 5)) begin
          entry_push = 1'b1;
          nibble_in  = 4'($urandom);
        end
        tick();
        entry_push = 1'b0;
      end
      chk("done_pulse", {busy, done, fail, id_we, pwd_we}, 5'b11000);
      tick();
      chk("done_end", {busy, done, phase}, 0);
      exp_succ++;
    end
    cnt_known = 1'b1;
  endtask

  task automatic reset_mid_pwd();
    slot_sel     = 2'd1;
    enroll_start = 1'b1;
    tick();
    enroll_start = 1'b0;
    for (int p = 0; p < 6; p++) begin
      nibble_in  = 4'($urandom);
      entry_push = 1'b1;
      tick();
      entry_push = 1'b0;
      m_disp     = nibble_in;
    end
    chk("pre_rst_phase", {phase, digit_cnt}, {2'd2, 2'd2});
    #2 rst = 1'b0;
    #1;
    chk("rst_outs", {id_we, id_waddr, id_wdata, pwd_we, pwd_waddr, pwd_wdata, busy, done,
                     fail, phase, digit_cnt, disp_nibble}, 0);
    tick();
    tick();
    rst       = 1'b1;
    m_disp    = '0;
    cnt_known = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    logic [15:0] idv, pwv, cfv, msk;
    int          cpos;
    for (int a = 0; a < 16; a++) begin ref_id[a] = '0; sh_id[a] = '0; end
    for (int a = 0; a < 32; a++) begin ref_pwd[a] = '0; sh_pwd[a] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {id_we, id_waddr, id_wdata, pwd_we, pwd_waddr, pwd_wdata, busy, done,
                        fail, phase, digit_cnt, disp_nibble}, 0);
    rst = 1'b1;
    tick();
    idle_push();

    do_enroll(2'd2, pk(4'h3, 4'hA, 4'h5, 4'hC), pk(4'h1, 4'h2, 4'h3, 4'h4),
              pk(4'h1, 4'h2, 4'h3, 4'h4), -1, 1'b0, 1'b1);
    do_enroll(2'd0, 16'($urandom), pk(4'h1, 4'h2, 4'h3, 4'h4),
              pk(4'h1, 4'h2, 4'h9, 4'h4), -1, 1'b0, 1'b0);
    do_enroll(2'd1, 16'($urandom), pk(4'h1, 4'h2, 4'h3, 4'h4),
              pk(4'h1, 4'h2, 4'h3, 4'h4), 10, 1'b0, 1'b0);
    idle_push();
    pwv = 16'($urandom);
    do_enroll(2'd3, 16'($urandom), pwv, pwv, -1, 1'b1, 1'b0);
    reset_mid_pwd();
    pwv = 16'($urandom);
    do_enroll(2'd0, 16'($urandom), pwv, pwv, -1, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      idv = 16'($urandom);
      pwv = 16'($urandom);
      cfv = pwv;
      if ($urandom_range(0, 2) == 0) begin
        msk = 16'h000F;
        msk = msk << (4 * $urandom_range(0, 3));
        cfv = pwv ^ (msk & 16'($urandom_range(1, 65535) | 16'h1111));
      end
      cpos = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 11)) : -1;
      if ($urandom_range(0, 3) == 0) idle_push();
      do_enroll(2'($urandom), idv, pwv, cfv, cpos, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0));
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    for (int a = 0; a < 16; a++) chk("id_ram", sh_id[a], ref_id[a]);
    for (int a = 0; a < 32; a++) chk("pwd_ram", sh_pwd[a], ref_pwd[a]);
    chk("id_writes", id_wr, 4 * exp_succ);
    chk("pwd_writes", pwd_wr, 4 * exp_succ);
    chk("both_we", both_wr, 0);
    chk("done_count", done_seen, exp_succ);
    chk("fail_count", fail_seen, exp_fail);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
